image_stream_reader: RTL and testbench

//  Read-side master for the byte-wide data memory image region. On start, it

---
 rtl/image_stream_reader.sv | 192 +++++++++++++++++++
 tb/tb_image_stream_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_reader.sv
// image_stream_reader: fetches a frame of bytes from data memory and
// streams them out as tagged pixels over a valid/ready port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      frame control; busy high while a frame runs
//   done              one-cycle pulse after the final pixel handshake
//   mem_addr          byte address driven to data memory
//   mem_read_en       one-cycle read strobe per byte
//   mem_rdata         read data, low byte is the pixel
//   pix_data/valid    pixel byte and valid, accepted on pix_ready
//   pix_x, pix_y      column and row of the pixel on the port
//   pix_last          marks the final pixel of the frame
module image_stream_reader #(
  parameter int N          = 32,
  parameter int BASE_ADDR  = 100,
  parameter int NUM_PIXELS = 2500,
  parameter int IMG_W      = 50,
  parameter int MEM_LAT    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] mem_addr,
  output logic         mem_read_en,
  input  logic [N-1:0] mem_rdata,
  output logic [7:0]   pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [15:0]  pix_x,
  output logic [15:0]  pix_y,
  output logic         pix_last
);

  localparam int CW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PIXELS - 1);
  localparam logic [15:0]   X_MAX    = 16'(IMG_W - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic [15:0]    x_q, x_d;
  logic [15:0]    y_q, y_d;
  logic [N-1:0]   mem_addr_q, mem_addr_d;
  logic           mem_read_en_q, mem_read_en_d;
  logic [7:0]     pix_data_q, pix_data_d;
  logic           pix_valid_q, pix_valid_d;
  logic           pix_last_q, pix_last_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [CW-1:0]  count_nx;

  // Only the low byte of the memory word carries pixel data.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[N-1:8];

  assign count_nx = count_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    lat_d         = lat_q;
    x_d           = x_q;
    y_d           = y_q;
    mem_addr_d    = mem_addr_q;
    mem_read_en_d = 1'b0;
    pix_data_d    = pix_data_q;
    pix_valid_d   = pix_valid_q;
    pix_last_d    = pix_last_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_REQ;
          busy_d        = 1'b1;
          count_d       = '0;
          x_d           = '0;
          y_d           = '0;
          mem_addr_d    = N'(BASE_ADDR);
          mem_read_en_d = 1'b1;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        lat_d   = LAT_INIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_d     = S_HOLD;
          pix_data_d  = mem_rdata[7:0];
          pix_valid_d = 1'b1;
          pix_last_d  = (count_q == LAST_IDX);
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_HOLD: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          if (count_q == LAST_IDX) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d       = S_REQ;
            count_d       = count_nx;
            mem_addr_d    = N'(BASE_ADDR) + N'(count_nx);
            mem_read_en_d = 1'b1;
            if (x_q == X_MAX) begin
              x_d = '0;
              y_d = y_q + 16'd1;
            end else begin
              x_d = x_q + 16'd1;
            end
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over a same-cycle handshake; the pixel is dropped.
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      busy_d        = 1'b0;
      pix_valid_d   = 1'b0;
      pix_last_d    = 1'b0;
      mem_read_en_d = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      lat_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      mem_addr_q    <= '0;
      mem_read_en_q <= 1'b0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      lat_q         <= lat_d;
      x_q           <= x_d;
      y_q           <= y_d;
      mem_addr_q    <= mem_addr_d;
      mem_read_en_q <= mem_read_en_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      pix_last_q    <= pix_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_addr    = mem_addr_q;
  assign mem_read_en = mem_read_en_q;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign pix_last    = pix_last_q;

endmodule

// File: tb/tb_image_stream_reader.sv
// tb_image_stream_reader: directed bench for image_stream_reader, with a
// default-latency instance (a_*) and a MEM_LAT=3 small-frame instance (b_*).
module tb_image_stream_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a: defaults
  logic        a_start = 0, a_abort = 0, a_ready = 1;
  logic        a_busy, a_done, a_rd, a_valid, a_last;
  logic [31:0] a_addr, a_rdata = 0;
  logic [7:0]  a_data;
  logic [15:0] a_x, a_y;

  // instance b: MEM_LAT=3, 3x4 frame at 200
  logic        b_start = 0, b_abort = 0, b_ready = 1;
  logic        b_busy, b_done, b_rd, b_valid, b_last;
  logic [31:0] b_addr, b_rdata = 0;
  logic [7:0]  b_data;
  logic [15:0] b_x, b_y;

  image_stream_reader u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done), .mem_addr(a_addr),
    .mem_read_en(a_rd), .mem_rdata(a_rdata), .pix_data(a_data),
    .pix_valid(a_valid), .pix_ready(a_ready), .pix_x(a_x),
    .pix_y(a_y), .pix_last(a_last)
  );

  image_stream_reader #(
    .N(32), .BASE_ADDR(200), .NUM_PIXELS(12), .IMG_W(4), .MEM_LAT(3)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .mem_addr(b_addr),
    .mem_read_en(b_rd), .mem_rdata(b_rdata), .pix_data(b_data),
    .pix_valid(b_valid), .pix_ready(b_ready), .pix_x(b_x),
    .pix_y(b_y), .pix_last(b_last)
  );

  // memories: data valid only for the exact latency slot, garbage otherwise
  always @(posedge clk)
    a_rdata <= a_rd ? ((a_addr - 32'd100) & 32'hFF) : 32'hDEAD_BEEF;

  logic [31:0] b_s1 = 0, b_s2 = 0;
  always @(posedge clk) begin
    b_s1    <= b_rd ? ((b_addr * 32'd7 + 32'd3) & 32'hFF) : 32'hDEAD_BEEF;
    b_s2    <= b_s1;
    b_rdata <= b_s2;
  end

  int mon_checks = 0, mon_errs = 0;
  int tst_checks = 0, tst_errs = 0;
  int n_checks, n_errors;

  task automatic mcheck(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
    mon_checks++;
    if (act !== exp) begin
      mon_errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tcheck(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
    tst_checks++;
    if (act !== exp) begin
      tst_errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // pixel capture for the table checks
  logic [7:0]  a_dat [0:2499];
  logic [15:0] a_xs  [0:2499];
  logic [15:0] a_ys  [0:2499];
  logic        a_lst [0:2499];

  int a_idx = 0, a_strb = 0, a_low = 0, a_dcnt = 0;
  bit a_prd = 0, a_pdone = 0;
  int b_idx = 0, b_strb = 0, b_low = 0, b_dcnt = 0;
  bit b_prd = 0, b_pdone = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rd) begin
        mcheck("a_strobe_width", a_prd, 0);
        if (a_strb > 0) mcheck("a_strobe_gap_ge2", a_low >= 2, 1);
        mcheck("a_strobe_addr", a_addr, 100 + a_strb);
        a_strb++;
        a_low = 0;
      end else a_low++;
      a_prd = a_rd;
      if (a_valid && a_ready && a_idx < 2500) begin
        mcheck("a_pix_data", a_data, a_idx & 255);
        mcheck("a_pix_x", a_x, a_idx % 50);
        mcheck("a_pix_y", a_y, a_idx / 50);
        mcheck("a_pix_last", a_last, a_idx == 2499);
        a_dat[a_idx] = a_data;
        a_xs[a_idx]  = a_x;
        a_ys[a_idx]  = a_y;
        a_lst[a_idx] = a_last;
        a_idx++;
      end
      if (a_done) begin
        mcheck("a_done_single", a_pdone, 0);
        mcheck("a_done_count", a_idx, 2500);
        a_dcnt++;
      end
      a_pdone = a_done;

      if (b_rd) begin
        mcheck("b_strobe_width", b_prd, 0);
        if (b_strb > 0) mcheck("b_strobe_gap_ge4", b_low >= 4, 1);
        mcheck("b_strobe_addr", b_addr, 200 + b_strb);
        b_strb++;
        b_low = 0;
      end else b_low++;
      b_prd = b_rd;
      if (b_valid && b_ready && b_idx < 12) begin
        mcheck("b_pix_data", b_data, ((200 + b_idx) * 7 + 3) & 255);
        mcheck("b_pix_x", b_x, b_idx % 4);
        mcheck("b_pix_y", b_y, b_idx / 4);
        mcheck("b_pix_last", b_last, b_idx == 11);
        b_idx++;
      end
      if (b_done) begin
        mcheck("b_done_single", b_pdone, 0);
        mcheck("b_done_count", b_idx, 12);
        b_dcnt++;
      end
      b_pdone = b_done;
    end
    if (!rst_n || !a_busy) begin
      a_idx = 0; a_strb = 0; a_low = 0; a_prd = 0;
    end
    if (!rst_n || !b_busy) begin
      b_idx = 0; b_strb = 0; b_low = 0; b_prd = 0;
    end
  end

  typedef struct {
    int idx;
    int x;
    int y;
    int data;
    bit last;
  } vec_t;

  vec_t vt [6];

  task automatic run_table();
    for (int i = 0; i < 6; i++) begin
      int k = vt[i].idx;
      tcheck($sformatf("px%0d_data", k), a_dat[k], vt[i].data);
      tcheck($sformatf("px%0d_x", k), a_xs[k], vt[i].x);
      tcheck($sformatf("px%0d_y", k), a_ys[k], vt[i].y);
      tcheck($sformatf("px%0d_last", k), a_lst[k], vt[i].last);
    end
  endtask

  task automatic check_zero_a(input string tag);
    tcheck({tag, "_busy"}, a_busy, 0);
    tcheck({tag, "_done"}, a_done, 0);
    tcheck({tag, "_addr"}, a_addr, 0);
    tcheck({tag, "_rd"}, a_rd, 0);
    tcheck({tag, "_data"}, a_data, 0);
    tcheck({tag, "_valid"}, a_valid, 0);
    tcheck({tag, "_x"}, a_x, 0);
    tcheck({tag, "_y"}, a_y, 0);
    tcheck({tag, "_last"}, a_last, 0);
  endtask

  task automatic pulse_start_a(output int c0);
    @(posedge clk);
    #1 a_start = 1;
    c0 = cyc;
    @(posedge clk);
    #1 a_start = 0;
  endtask

  task automatic wait_strobe_a(input logic [31:0] addr);
    bit hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (a_rd && a_addr == addr) hit = 1;
    end
    tcheck($sformatf("strobe_%0d_seen", addr), hit, 1);
  endtask

  task automatic run_frame_a(input bit poke_start);
    int c0;
    int dc;
    bit hit = 0;
    dc = a_dcnt;
    pulse_start_a(c0);
    for (int i = 0; i < 8000 && !hit; i++) begin
      @(negedge clk);
      if (poke_start && i == 300) a_start = 1;
      if (poke_start && i == 301) a_start = 0;
      if (a_done) hit = 1;
    end
    tcheck("frame_done_seen", hit, 1);
    tcheck("frame_busy_at_done", a_busy, 1);
    tcheck("frame_cycles_ge_7502", (cyc - c0 + 1) >= 7502, 1);
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    tcheck("idle_busy_after_fin", a_busy, 0);
    tcheck("idle_done_after_fin", a_done, 0);
    @(negedge clk);
    tcheck("start_with_done_ignored", a_busy, 0);
    tcheck("done_pulses", a_dcnt, dc + 1);
    run_table();
  endtask

  initial begin
    int dc;
    int c0;
    bit hit;

    vt[0] = '{0,    0,  0,  0,   1'b0};
    vt[1] = '{49,   49, 0,  49,  1'b0};
    vt[2] = '{50,   0,  1,  50,  1'b0};
    vt[3] = '{255,  5,  5,  255, 1'b0};
    vt[4] = '{256,  6,  5,  0,   1'b0};
    vt[5] = '{2499, 49, 49, 195, 1'b1};

    #3 check_zero_a("reset");
    @(posedge clk);
    #1 rst_n = 1;

    // full frame, plus a start while busy that must be ignored
    run_frame_a(1'b1);

    // backpressure on pixel 7, then abort in WAIT of pixel 10
    pulse_start_a(c0);
    wait_strobe_a(107);
    a_ready = 0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      tcheck("stall_valid", a_valid, 1);
      tcheck("stall_data", a_data, 7);
      tcheck("stall_x", a_x, 7);
      tcheck("stall_y", a_y, 0);
      tcheck("stall_no_rd", a_rd, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 a_ready = 1;
    wait_strobe_a(108);
    wait_strobe_a(110);
    dc = a_dcnt;
    @(posedge clk);
    #1 a_abort = 1;
    @(posedge clk);
    #1 a_abort = 0;
    tcheck("abort_busy", a_busy, 0);
    tcheck("abort_valid", a_valid, 0);
    tcheck("abort_rd", a_rd, 0);
    repeat (10) @(negedge clk);
    tcheck("abort_no_done", a_dcnt, dc);
    tcheck("abort_stays_idle", a_busy, 0);

    // restart from base, then async reset mid-HOLD
    pulse_start_a(c0);
    wait_strobe_a(100);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (a_valid && a_x == 5) hit = 1;
    end
    tcheck("hold_px5_seen", hit, 1);
    tcheck("hold_px5_data", a_data, 5);
    #2 rst_n = 0;
    #1 check_zero_a("async_rst");
    @(posedge clk);
    #1 rst_n = 1;
    run_frame_a(1'b0);

    // MEM_LAT=3 instance
    dc = b_dcnt;
    @(posedge clk);
    #1 b_start = 1;
    c0 = cyc;
    @(posedge clk);
    #1 b_start = 0;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (b_done) hit = 1;
    end
    tcheck("b_done_seen", hit, 1);
    tcheck("b_cycles_ge_62", (cyc - c0 + 1) >= 62, 1);
    @(negedge clk);
    tcheck("b_done_pulses", b_dcnt, dc + 1);
    tcheck("b_idle_busy", b_busy, 0);

    repeat (3) @(negedge clk);
    n_checks = tst_checks + mon_checks;
    n_errors = tst_errs + mon_errs;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
